// File: rtl/servo_pkg.sv
// Shared types and constants for the servo sort sequencer.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD       = 2'd1,
    ST_SETTLE     = 2'd2,
    ST_WAIT_CLEAR = 2'd3
  } servo_state_e;

  localparam logic DIR_LEFT     = 1'b1;
  localparam logic DIR_VERTICAL = 1'b0;

  localparam int unsigned COUNT_W = 16;

  // Saturating increment for the package statistics counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus level debouncer for the package-present sensor.
// level_out moves only after the synchronised input has differed from it for DEBOUNCE_CYCLES cycles.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_q1;
  logic sync_q2;
  logic level_d;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      level_out <= 1'b0;
      level_d   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
      level_d <= level_out;
      if (sync_q2 == level_out) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_TC) begin
        level_out <= sync_q2;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_pulse = level_out & ~level_d;

endmodule

// File: rtl/servo_sort_sequencer.sv
// Package diverter sequencer: debounced detection drives a timed LEFT/VERTICAL servo command.
// Optional package statistics outputs are built when SERVO_SORT_COUNT_EN is defined.
//
// state         | meaning
// ST_IDLE       | armed, waiting for a debounced package detection
// ST_HOLD       | servo held LEFT for DWELL_CYCLES
// ST_SETTLE     | servo back VERTICAL for SETTLE_CYCLES before re-arming
// ST_WAIT_CLEAR | waiting for the debounced sensor to read clear
module servo_sort_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 50000000,
  parameter int unsigned SETTLE_CYCLES   = 25000000
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               sensor_raw,
  input  logic               sort_left,
  output logic               control_out,
  output logic               busy,
`ifdef SERVO_SORT_COUNT_EN
  output logic [COUNT_W-1:0] left_count,
  output logic [COUNT_W-1:0] pass_count,
`endif
  output logic               done_pulse
);

  localparam int unsigned DWELL_W  = $clog2(DWELL_CYCLES);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES);
  localparam logic [DWELL_W-1:0]  DWELL_TC  = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_TC = SETTLE_W'(SETTLE_CYCLES - 1);

  servo_state_e state_q;
  servo_state_e state_d;
  logic [DWELL_W-1:0]  dwell_q;
  logic [SETTLE_W-1:0] settle_q;
  logic level;
  logic detect;
  logic control_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .raw_in    (sensor_raw),
    .level_out (level),
    .rise_pulse(detect)
  );

  // Timers are loaded one state ahead so each expires on the last cycle of its state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      control_out <= DIR_VERTICAL;
      dwell_q     <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      control_out <= control_d;
      if (state_q == ST_IDLE && detect) begin
        dwell_q <= DWELL_TC;
      end else if (state_q == ST_HOLD && dwell_q != '0) begin
        dwell_q <= dwell_q - 1'b1;
      end
      if (state_q == ST_HOLD && dwell_q == '0) begin
        settle_q <= SETTLE_TC;
      end else if (state_q == ST_SETTLE && settle_q != '0) begin
        settle_q <= settle_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (detect) state_d = (sort_left == DIR_LEFT) ? ST_HOLD : ST_WAIT_CLEAR;
      ST_HOLD:       if (dwell_q == '0) state_d = ST_SETTLE;
      ST_SETTLE:     if (settle_q == '0) state_d = ST_WAIT_CLEAR;
      ST_WAIT_CLEAR: if (!level) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    control_d  = (state_d == ST_HOLD) ? DIR_LEFT : DIR_VERTICAL;
    busy       = (state_q != ST_IDLE);
    done_pulse = (state_q == ST_WAIT_CLEAR) && !level;
  end

`ifdef SERVO_SORT_COUNT_EN
  logic dir_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= DIR_VERTICAL;
      left_count <= '0;
      pass_count <= '0;
    end else begin
      if (state_q == ST_IDLE && detect) dir_q <= sort_left;
      if (done_pulse) begin
        if (dir_q == DIR_LEFT) left_count <= sat_inc(left_count);
        else                   pass_count <= sat_inc(pass_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_servo_sort_sequencer.sv
// Scoreboard bench for servo_sort_sequencer: stimulus queues expected HOLD lengths and
// busy-run lengths at done_pulse; a negedge monitor pops and compares them.
module tb_servo_sort_sequencer;

  localparam int DEB    = 4;
  localparam int DWELL  = 10;
  localparam int SETTLE = 5;

  localparam int EV_HOLD = 0;
  localparam int EV_DONE = 1;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic sensor_raw = 1'b0;
  logic sort_left = 1'b0;
  logic control_out;
  logic busy;
  logic done_pulse;
`ifdef SERVO_SORT_COUNT_EN
  logic [15:0] left_count;
  logic [15:0] pass_count;
`endif

  ev_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hold_run = 0;
  int busy_run = 0;

  always #10 clk_in = ~clk_in;

  servo_sort_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sensor_raw (sensor_raw),
    .sort_left  (sort_left),
    .control_out(control_out),
    .busy       (busy),
`ifdef SERVO_SORT_COUNT_EN
    .left_count (left_count),
    .pass_count (pass_count),
`endif
    .done_pulse (done_pulse)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: got value %0d, expected no event",
               (kind == EV_HOLD) ? "hold" : "done", val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check((e.kind == EV_HOLD) ? "hold_len" : "done_busy_len", val, e.val);
    end
  endtask

  // Monitor: control_out high-run lengths and busy-run length at each done_pulse.
  initial begin
    forever begin
      @(negedge clk_in);
      if (control_out) hold_run++;
      else if (hold_run != 0) begin
        observe(EV_HOLD, hold_run);
        hold_run = 0;
      end
      if (busy) busy_run++;
      else busy_run = 0;
      if (done_pulse) observe(EV_DONE, busy_run);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Raw high for `high` clock edges, starting at the current negedge.
  task automatic pulse_raw(input int high);
    sensor_raw = 1'b1;
    repeat (high) @(negedge clk_in);
    sensor_raw = 1'b0;
  endtask

  task automatic wait_ctrl_high(output int ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (control_out) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int seen_busy;
    int seen_ctrl;
    int ok;

    repeat (3) @(negedge clk_in);
    check("reset_control_out", int'(control_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done_pulse", int'(done_pulse), 0);
    #2 rst_n = 1'b1;
    idle(5);

    // LEFT, sensor still present after settle: done waits for the sensor to clear
    sort_left = 1'b1;
    push(EV_HOLD, 10);
    push(EV_DONE, 30);
    pulse_raw(30);
    sort_left = 1'b0;
    idle(40);

    // LEFT, sensor already clear: done on first WAIT_CLEAR cycle (10 hold + 5 settle + 1)
    sort_left = 1'b1;
    push(EV_HOLD, 10);
    push(EV_DONE, 16);
    pulse_raw(8);
    sort_left = 1'b0;
    idle(40);

    // VERTICAL packages: control_out never rises
    push(EV_DONE, 20);
    pulse_raw(20);
    idle(40);
    push(EV_DONE, 6);
    pulse_raw(6);
    idle(40);

    // Two-cycle glitch must not be accepted
    sort_left = 1'b1;
    pulse_raw(2);
    seen_busy = 0;
    seen_ctrl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (busy) seen_busy = 1;
      if (control_out) seen_ctrl = 1;
    end
    check("glitch_busy", seen_busy, 0);
    check("glitch_control_out", seen_ctrl, 0);

    // Sensor re-triggers and sort_left flips during HOLD: both ignored
    push(EV_HOLD, 10);
    push(EV_DONE, 20);
    sensor_raw = 1'b1;
    idle(4);
    sensor_raw = 1'b0;
    idle(4);
    sensor_raw = 1'b1;
    idle(2);
    sort_left = 1'b0;
    idle(10);
    sensor_raw = 1'b0;
    idle(40);

`ifdef SERVO_SORT_COUNT_EN
    check("left_count", int'(left_count), 3);
    check("pass_count", int'(pass_count), 2);
    dut.left_count = 16'hFFFF;
    sort_left = 1'b1;
    push(EV_HOLD, 10);
    push(EV_DONE, 16);
    pulse_raw(8);
    sort_left = 1'b0;
    idle(40);
    check("left_count_saturated", int'(left_count), 32'hFFFF);
    check("pass_count_unchanged", int'(pass_count), 2);
`endif

    // Reset during the fifth HOLD cycle, then the still-present sensor is detected again
    sort_left = 1'b1;
    sensor_raw = 1'b1;
    push(EV_HOLD, 5);
    wait_ctrl_high(ok);
    check("hold_start_seen", ok, 1);
    idle(4);
    #2 rst_n = 1'b0;
    sort_left = 1'b0;
    #1;
    check("async_reset_control_out", int'(control_out), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done_pulse", int'(done_pulse), 0);
    idle(3);
    push(EV_DONE, 15);
    #2 rst_n = 1'b1;
    idle(15);
    sensor_raw = 1'b0;
    idle(40);

    check("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
